// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// address-field width helpers and the mem_addr reset value.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFILL  = 2'd1,
        ST_INSTALL = 2'd2
    } state_t;

    localparam logic [31:0] RESET_VEC = 32'h0;

    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int num_lines, input int line_words);
        return 32 - idx_w(num_lines) - off_w(line_words);
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for every cache line, with a combinational compare
// port, a single-line set port, a single-line invalidate and a clear-all.
module icache_tag_array #(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = 6,
    parameter int TAG_W     = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IDX_W-1:0] lookup_idx,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             match,
    input  logic             inval_en,
    input  logic [IDX_W-1:0] inval_idx,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clear_all
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_arr [NUM_LINES];

    assign match = valid_q[lookup_idx] && (tag_arr[lookup_idx] == lookup_tag);

    // clear_all wins over any per-line update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (en) begin
            if (clear_all) begin
                valid_q <= '0;
            end else begin
                if (inval_en) valid_q[inval_idx] <= 1'b0;
                if (set_en)   valid_q[set_idx]   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && set_en) tag_arr[set_idx] <= set_tag;
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with sequential line refill.
// Define ICACHE_STATS_EN to add the hit_cnt / miss_cnt statistics outputs.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc,
    output logic        hit,
    output logic [31:0] inst_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    input  logic        flush,
    output state_t      dbg_state
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(NUM_LINES, LINE_WORDS);
    localparam int CNT_W = OFF_W - 2;

    // Handshake: mem_req stays high for the whole refill; each one-cycle
    // mem_done (with rdy high) delivers mem_data for the current mem_addr.
    logic [CNT_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_pc_lsb;

    assign off           = pc[OFF_W-1:2];
    assign idx           = pc[OFF_W+IDX_W-1:OFF_W];
    assign tag           = pc[31:OFF_W+IDX_W];
    assign unused_pc_lsb = ^pc[1:0];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] miss_idx_q;
    logic [TAG_W-1:0] miss_tag_q;
    logic             flush_pend_q;
    logic             line_match;
    logic             last_word;
    logic             refill_start;
    logic             word_wr;
    logic             flush_any;
    logic             set_en;
    logic             clear_all;
    logic [31:0]      data_arr [NUM_LINES*LINE_WORDS];

    assign last_word    = (cnt_q == CNT_W'(LINE_WORDS - 1));
    assign hit          = (state_q == ST_IDLE) && line_match;
    assign refill_start = rdy && (state_q == ST_IDLE) && !line_match;
    assign word_wr      = rdy && !rst && (state_q == ST_REFILL) && mem_done;
    assign flush_any    = flush_pend_q || flush;
    assign set_en       = (state_q == ST_INSTALL) && !flush_any;
    assign clear_all    = ((state_q == ST_IDLE) && flush) ||
                          ((state_q == ST_INSTALL) && flush_any);
    assign dbg_state    = state_q;
    assign inst_out     = data_arr[{idx, off}];

    // The victim's valid bit drops at refill start so a conflicting pc
    // can never hit on a half-written line.
    icache_tag_array #(
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_tags (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .lookup_idx(idx),
        .lookup_tag(tag),
        .match     (line_match),
        .inval_en  (refill_start),
        .inval_idx (idx),
        .set_en    (set_en),
        .set_idx   (miss_idx_q),
        .set_tag   (miss_tag_q),
        .clear_all (clear_all)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (!line_match) state_d = ST_REFILL;
            ST_REFILL:  if (mem_done && last_word) state_d = ST_INSTALL;
            ST_INSTALL: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
            flush_pend_q <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= RESET_VEC;
        end else if (rdy) begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (!line_match) begin
                        miss_idx_q <= idx;
                        miss_tag_q <= tag;
                        cnt_q      <= '0;
                        mem_req    <= 1'b1;
                        mem_addr   <= {pc[31:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                ST_REFILL: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (mem_done) begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                        mem_addr <= mem_addr + 32'd4;
                        if (last_word) mem_req <= 1'b0;
                    end
                end
                ST_INSTALL: flush_pend_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (word_wr) data_arr[{miss_idx_q, cnt_q}] <= mem_data;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy) begin
            if (hit)          hit_cnt  <= hit_cnt + 32'd1;
            if (refill_start) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, conflict, pc change mid-refill,
// flush, rdy stall and (with ICACHE_STATS_EN) the statistics counters.
module tb_icache;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] inst_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        flush;
    state_t      dbg_state;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    icache dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .pc       (pc),
        .hit      (hit),
        .inst_out (inst_out),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_done (mem_done),
        .mem_data (mem_data),
        .flush    (flush),
        .dbg_state(dbg_state)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Backing memory contents: every word address maps to a distinct value.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Controller answers each request after one idle cycle.
    task automatic serve_word(input logic [31:0] a);
        check("mem_addr", mem_addr, a);
        check("mem_req", 32'(mem_req), 32'd1);
        step();
        mem_data = mw(a);
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        mem_data = 32'h0;
    endtask

    task automatic fill_line(input logic [31:0] base);
        pc = base;
        #1;
        check("miss_hit", 32'(hit), 32'd0);
        step();
        check("refill_state", 32'(dbg_state), 32'(ST_REFILL));
        for (int i = 0; i < 4; i++) serve_word(base + 32'(4 * i));
        check("install_state", 32'(dbg_state), 32'(ST_INSTALL));
        check("install_hit", 32'(hit), 32'd0);
        check("install_req", 32'(mem_req), 32'd0);
        step();
        check("filled_hit", 32'(hit), 32'd1);
        check("filled_inst", inst_out, mw(base));
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; pc = 32'h0; mem_done = 1'b0; mem_data = 32'h0; flush = 1'b0;
        repeat (3) step();
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // Cold miss at 0x0, then a hit on word 2 of the same line.
        fill_line(32'h0);
        pc = 32'h8; #1;
        check("cold_w2_hit", 32'(hit), 32'd1);
        check("cold_w2_inst", inst_out, mw(32'h8));

        // 0x400 shares idx 0 with 0x0 and evicts it.
        fill_line(32'h400);
        pc = 32'h0; #1;
        check("evicted_hit", 32'(hit), 32'd0);
        fill_line(32'h0);

        // pc switches to 0x200 after the second word of the 0x100 refill.
        pc = 32'h100;
        step();
        serve_word(32'h100);
        serve_word(32'h104);
        pc = 32'h200;
        serve_word(32'h108);
        serve_word(32'h10C);
        check("pcchg_install", 32'(dbg_state), 32'(ST_INSTALL));
        check("pcchg_inst_hit", 32'(hit), 32'd0);
        step();
        check("pcchg_idle_hit", 32'(hit), 32'd0);
        step();
        check("pcchg_refill", 32'(dbg_state), 32'(ST_REFILL));
        for (int i = 0; i < 4; i++) serve_word(32'h200 + 32'(4 * i));
        step();
        check("pc200_hit", 32'(hit), 32'd1);
        check("pc200_inst", inst_out, mw(32'h200));
        pc = 32'h10C; #1;
        check("pc10c_hit", 32'(hit), 32'd1);
        check("pc10c_inst", inst_out, mw(32'h10C));

        // Flush raised mid-refill of 0x40: line never installs, all invalid.
        pc = 32'h40;
        step();
        serve_word(32'h40);
        flush = 1'b1;
        step();
        flush = 1'b0;
        serve_word(32'h44);
        serve_word(32'h48);
        serve_word(32'h4C);
        check("flush_install", 32'(dbg_state), 32'(ST_INSTALL));
        step();
        check("flush_idle", 32'(dbg_state), 32'(ST_IDLE));
        pc = 32'h0;   #1; check("flush_0_hit", 32'(hit), 32'd0);
        pc = 32'h100; #1; check("flush_100_hit", 32'(hit), 32'd0);
        pc = 32'h200; #1; check("flush_200_hit", 32'(hit), 32'd0);
        fill_line(32'h40);

        // Flush in IDLE: hit still seen in the flush cycle, gone after.
        flush = 1'b1; #1;
        check("iflush_same_hit", 32'(hit), 32'd1);
        step();
        flush = 1'b0; #1;
        check("iflush_after_hit", 32'(hit), 32'd0);
        step();

        // rdy drops for 5 cycles in the middle of the 0x40 refill.
        check("stall_refill", 32'(dbg_state), 32'(ST_REFILL));
        serve_word(32'h40);
        serve_word(32'h44);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_addr", mem_addr, 32'h48);
            check("stall_state", 32'(dbg_state), 32'(ST_REFILL));
            check("stall_req", 32'(mem_req), 32'd1);
        end
        rdy = 1'b1;
        serve_word(32'h48);
        serve_word(32'h4C);
        step();
        for (int i = 0; i < 4; i++) begin
            pc = 32'h40 + 32'(4 * i); #1;
            check("stall_hit", 32'(hit), 32'd1);
            check("stall_inst", inst_out, mw(32'h40 + 32'(4 * i)));
        end

        // A stray mem_done while idle must not disturb anything.
        pc = 32'h48;
        mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
        step();
        mem_done = 1'b0; mem_data = 32'h0;
        check("idle_done_state", 32'(dbg_state), 32'(ST_IDLE));
        check("idle_done_hit", 32'(hit), 32'd1);
        check("idle_done_inst", inst_out, mw(32'h48));

`ifdef ICACHE_STATS_EN
        rst = 1'b1;
        step();
        check("stat_rst_hits", hit_cnt, 32'd0);
        check("stat_rst_miss", miss_cnt, 32'd0);
        rst = 1'b0;
        pc = 32'h0;
        fill_line(32'h0);
        fill_line(32'h10);
        repeat (10) step();
        check("stat_hits", hit_cnt, 32'd10);
        check("stat_miss", miss_cnt, 32'd2);
        rdy = 1'b0;
        repeat (3) step();
        check("stat_frozen_hits", hit_cnt, 32'd10);
        check("stat_frozen_miss", miss_cnt, 32'd2);
        rdy = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
- Performs a combinational lookup on the fetch pc and returns hit/instruction in the same cycle.
- On a miss, refills the whole line word-by-word from the memory controller, then the lookup hits.
- Single outstanding refill; no write path.

Parameters:
- NUM_LINES, 64, number of lines; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; when low, all state freezes
- pc  in  32  fetch address; bits [1:0] ignored
- hit  out  1  pc line valid and tag matches, not during the refill-install cycle
- inst_out  out  32  word at pc, valid when hit=1
- mem_req  out  1  refill word request, held high for the whole refill
- mem_addr  out  32  word-aligned address of the requested word
- mem_done  in  1  one-cycle pulse: mem_data holds the word for mem_addr
- mem_data  in  32  refill data
- flush  in  1  invalidate all lines (fence.i)

Behaviour:
- Address split:
  - off = pc[OFF_W-1:2], where OFF_W = log2(LINE_WORDS)+2.
  - idx = pc[OFF_W+IDX_W-1:OFF_W], where IDX_W = log2(NUM_LINES).
  - tag = remaining upper bits, TAG_W = 32-IDX_W-OFF_W (22 bits at the defaults).
- Storage: valid[NUM_LINES], tag array, data array of NUM_LINES*LINE_WORDS words.
- hit = (state==IDLE) && valid[idx] && tag_arr[idx]==tag. It is combinational, so latency is 0.
- inst_out = data[idx][off], combinational. Its value is don't-care when hit=0.
- Reset: all valid cleared, state IDLE, mem_req=0, mem_addr=0, word counter 0.
- rst has priority over rdy. When rdy=0, nothing changes; mem_done pulses during rdy=0 are lost, so the controller must not issue them.
- FSM states: IDLE, REFILL, INSTALL.
  - IDLE to REFILL on a miss (valid[idx]==0 or tag mismatch).
    - Latch miss_tag and miss_idx.
    - cnt=0, mem_req<=1, mem_addr<={pc[31:OFF_W], OFF_W'b0}.
  - REFILL, on each mem_done:
    - Write mem_data into data[miss_idx][cnt], then cnt<=cnt+1.
    - mem_addr<=mem_addr+4, effective the next cycle.
    - On the last word (cnt==LINE_WORDS-1): mem_req<=0, go to INSTALL.
  - INSTALL (one cycle): valid[miss_idx]<=1, tag_arr[miss_idx]<=miss_tag, go to IDLE. hit=0 in this cycle.
  - The refill is always sequential from word 0, with no critical-word-first.
- pc changing during REFILL: the refill completes for the latched line and is never aborted. The new pc is looked up after INSTALL and may miss again.
- flush in IDLE: all valid bits clear next cycle. hit is still computed from the old state in the flush cycle.
- flush during REFILL or INSTALL: is registered as pending. The refill completes and the line is not installed (INSTALL skips setting valid). Then all valid bits clear.
- mem_done while in IDLE is ignored.
- Line replacement overwrites the old line's data. The old line's valid bit is cleared at refill start, so a conflicting pc cannot hit on partial data.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, two extra outputs are added:
  - hit_cnt[31:0] counts cycles with rdy && hit.
  - miss_cnt[31:0] counts IDLE to REFILL transitions.
  - Both reset to 0, wrap at 2^32, and are frozen when rdy=0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the FSM state encoding;
  - the OFF_W, IDX_W and TAG_W derivation functions;
  - the reset vector constant 32'h0.
- One natural sub-module: icache_tag_array, holding valid and tag storage with a combinational compare port, a set port and a clear-all port.
- Data storage stays inline in the top.

Test Plan:
- Cold miss:
  - Stimulus: after reset, pc=0x0; memory returns 4 words with 1-cycle latency each.
  - Required: hit=0 and mem_addr sequence 0x0, 0x4, 0x8, 0xC. After INSTALL, hit=1 and inst_out equals word 0. pc=0x8 then hits with word 2.
- Conflict eviction:
  - Stimulus: fill line for pc=0x0, then pc=0x400 (same idx at defaults).
  - Required: miss with refill at 0x400. Afterwards pc=0x0 misses again.
- pc change mid-refill:
  - Stimulus: start refill for 0x100, switch pc to 0x200 after the 2nd mem_done.
  - Required: mem_addr continues 0x108, 0x10C. After INSTALL a new refill starts at 0x200, and 0x100 hits later.
- Flush:
  - Stimulus: flush asserted during a refill of 0x40.
  - Required: refill completes, line not installed, all lines invalid. pc=0x40 misses again.
- rdy stall:
  - Stimulus: drop rdy for 5 cycles mid-refill.
  - Required: mem_addr, the counter and the state are unchanged throughout. Resume produces correct data.
- ICACHE_STATS_EN:
  - Stimulus: 2 misses then 10 hit cycles.
  - Required: miss_cnt=2, hit_cnt=10.
